tx_frame_sched: RTL and testbench
=================================

Name: tx_frame_sched

Overview:
- Frame scheduler that sequences the d/k word stream feeding the link-side CRC inserter.
- Round-robin arbitrates N_REQ payload sources and builds each frame as: idle commas (CRC reset), payload words, one EOF comma, one CRC slot word.
- Inserts padding words on source stalls, so CRC accumulation and K history in the CRC block are not disturbed.
- Sits between the per-source readout buffers and the CRC inserter on the transmit path.

Parameters:
- N_REQ, 4, number of payload sources
- LEN_W, 8, width of frame length field, in words
- IDLE_MIN, 3, minimum consecutive commas before a frame starts; 3 guarantees a CRC reset
- STALL_MAX, 255, maximum consecutive padding words inside a frame before abort

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  allow new grants; a frame in flight always completes
- src_req  in  N_REQ  source has a frame pending
- src_len  in  N_REQ*LEN_W  payload length in words, per source, flat
- src_data  in  N_REQ*32  first-word-fall-through data, per source, flat
- src_dvalid  in  N_REQ  src_data word valid
- src_rd  out  N_REQ  pop strobe, combinational, one-hot
- src_done  out  N_REQ  1-cycle pulse when a frame ends or is dropped
- d  out  32  data to CRC inserter, registered
- k  out  4  K flags to CRC inserter, registered
- busy  out  1  frame in progress
- err_abort  out  1  1-cycle pulse on stall-timeout abort
- frame_cnt  out  16  completed frames, wraps

Behaviour:
- Word encoding:
  - Comma: d=COMMA_WORD (0x000000BC), k=4'h1.
  - Data: k=4'h0.
  - Padding: d=PAD_WORD (0xF7F7F7F7), k=4'hF.
- Reset (async, rst_n=0):
  - d=COMMA_WORD, k=4'h1; busy=0; src_rd=0; src_done=0; err_abort=0; frame_cnt=0.
  - idle_cnt=0, rr pointer=0, state=IDLE.
  - A reset mid-frame discards the frame; no src_done.
- IDLE:
  - Emit a comma every cycle; idle_cnt saturates at IDLE_MIN.
  - Grant when en=1, idle_cnt==IDLE_MIN and any src_req=1.
  - Winner is chosen round-robin, starting after the last grant.
  - On grant, latch the grant index and src_len; set busy.
  - If the latched len==0: pulse src_done, return to IDLE with busy=0, idle_cnt unchanged, no words emitted.
  - Otherwise go to PAYLOAD. The grant cycle itself still emits a comma.
- PAYLOAD:
  - If src_dvalid[g]=1: assert src_rd[g] the same cycle, register d=src_data[g], k=4'h0, decrement word_cnt, clear stall_cnt.
  - Else: emit padding, increment stall_cnt.
  - When the last word is popped (word_cnt==1), go to EOF_K.
  - If stall_cnt reaches STALL_MAX: pulse err_abort and src_done[g], clear idle_cnt, go to IDLE with busy=0.
  - No EOF comma or CRC slot is sent on abort; the trailing commas reset the CRC.
- EOF_K:
  - Emit exactly one comma; go to CRC_SLOT.
- CRC_SLOT:
  - Emit d=32'h0, k=4'h0; the CRC inserter replaces this word with the CRC.
  - Pulse src_done[g]; increment frame_cnt; clear idle_cnt, busy; go to IDLE.
- Latency: src_data to d is 1 cycle; src_rd and d-valid are aligned with one cycle of offset.
- No padding is ever emitted in EOF_K or CRC_SLOT, or between them.
- en deasserted mid-frame has no effect until the frame returns to IDLE.
- src_req dropped after grant is ignored; the frame runs on src_dvalid only.
- word_cnt is LEN_W bits; the maximum length 2^LEN_W-1 must not wrap.

Decomposition:
- Package tx_frame_pkg holds:
  - COMMA_WORD, PAD_WORD.
  - K_DATA, K_COMMA, K_PAD.
  - State enum {IDLE, PAYLOAD, EOF_K, CRC_SLOT}.
- Sub-module rr_arb(N_REQ): request vector plus advance strobe in; one-hot grant and index out; pointer state internal, reset to 0.

Test Plan:
- Reset release, src_req=0:
  - Required: continuous commas (d=0xBC, k=1); busy=0; no grant before 3 commas.
- src_req[0]=1, len=2, data 0x11111111 and 0x22222222 always valid:
  - Required sequence: comma×≥3, 0x11111111/k0, 0x22222222/k0, comma, 0x0/k0.
  - Required: src_done[0] pulse; frame_cnt=1.
- Same frame with src_dvalid low for 2 cycles mid-frame:
  - Required: two 0xF7F7F7F7/kF words between the payload words; CRC slot unchanged.
- src_req=4'b1111, len=1 each, held:
  - Required: grants in order 0,1,2,3,0.
  - Required: ≥3 commas between consecutive frames.
- len=0 on src 2:
  - Required: src_done[2] pulse; no data words; next request is granted without extra idle.
- src_dvalid stuck low, STALL_MAX=4:
  - Required: 4 pads, err_abort pulse, commas resume, frame_cnt unchanged.
  - Assert rst_n=0 mid-payload: required d=0xBC, k=1 immediately.

Source files
------------

// File: rtl/tx_frame_pkg.sv
// Shared encodings and FSM state type for the transmit frame scheduler.
package tx_frame_pkg;
  localparam logic [31:0] COMMA_WORD = 32'h0000_00BC;
  localparam logic [31:0] PAD_WORD   = 32'hF7F7_F7F7;
  localparam logic [3:0]  K_DATA     = 4'h0;
  localparam logic [3:0]  K_COMMA    = 4'h1;
  localparam logic [3:0]  K_PAD      = 4'hF;

  typedef enum logic [1:0] {IDLE, PAYLOAD, EOF_K, CRC_SLOT} state_e;
endpackage

// File: rtl/tx_frame_sched_if.sv
// Source-side request/readout bus and CRC-inserter-side word stream.
interface tx_frame_sched_if #(
  parameter int N_REQ = 4,
  parameter int LEN_W = 8
);
  logic                     en;
  logic [N_REQ-1:0]         src_req;
  logic [N_REQ*LEN_W-1:0]   src_len;
  logic [N_REQ*32-1:0]      src_data;
  logic [N_REQ-1:0]         src_dvalid;
  logic [N_REQ-1:0]         src_rd;
  logic [N_REQ-1:0]         src_done;
  logic [31:0]              d;
  logic [3:0]               k;
  logic                     busy;
  logic                     err_abort;
  logic [15:0]              frame_cnt;

  modport master (
    output en, src_req, src_len, src_data, src_dvalid,
    input  src_rd, src_done, d, k, busy, err_abort, frame_cnt
  );
  modport slave (
    input  en, src_req, src_len, src_data, src_dvalid,
    output src_rd, src_done, d, k, busy, err_abort, frame_cnt
  );
endinterface

// File: rtl/tx_frame_sched_rr_arb.sv
// Round-robin arbiter; search starts one past the last advanced grant.
module rr_arb #(
  parameter  int N_REQ = 4,
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             adv,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] idx
);
  logic [IDX_W-1:0] ptr;

  // Scan from farthest to nearest so the nearest requester after ptr wins.
  always_comb begin
    int j;
    j   = 0;
    gnt = '0;
    idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      j = (int'(ptr) + i) % N_REQ;
      if (req[j]) begin
        gnt    = '0;
        gnt[j] = 1'b1;
        idx    = IDX_W'(j);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   ptr <= '0;
    else if (adv) ptr <= IDX_W'((int'(idx) + 1) % N_REQ);
  end
endmodule

// File: rtl/tx_frame_sched.sv
// Frame scheduler: commas, payload (padded on stalls), EOF comma, CRC slot.
module tx_frame_sched
  import tx_frame_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int LEN_W     = 8,
  parameter int IDLE_MIN  = 3,
  parameter int STALL_MAX = 255
) (
  input logic              clk,
  input logic              rst_n,
  tx_frame_sched_if.slave  bus
);
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int IC_W  = $clog2(IDLE_MIN + 1);
  localparam int SC_W  = $clog2(STALL_MAX + 1);

  state_e            state, state_nx;
  logic [IDX_W-1:0]  g, g_nx;
  logic [LEN_W-1:0]  word_cnt, wc_nx;
  logic [SC_W-1:0]   stall_cnt, sc_nx;
  logic [IC_W-1:0]   idle_cnt, ic_nx;
  logic [31:0]       d_nx;
  logic [3:0]        k_nx;
  logic              busy_nx, abort_nx, fin;
  logic [N_REQ-1:0]  done_nx, arb_gnt, g_oh;
  logic [IDX_W-1:0]  arb_idx;
  logic              grant, dvalid_g;
  logic [31:0]       data_g;
  logic [LEN_W-1:0]  len_sel;

  assign grant    = (state == IDLE) && bus.en && (idle_cnt == IC_W'(IDLE_MIN)) && (|bus.src_req);
  assign g_oh     = N_REQ'(1) << g;
  assign dvalid_g = bus.src_dvalid[g];
  assign data_g   = bus.src_data[int'(g)*32 +: 32];
  assign len_sel  = bus.src_len[int'(arb_idx)*LEN_W +: LEN_W];
  assign bus.src_rd = (state == PAYLOAD && dvalid_g) ? g_oh : '0;

  rr_arb #(.N_REQ(N_REQ)) u_arb (
    .clk(clk), .rst_n(rst_n), .req(bus.src_req), .adv(grant), .gnt(arb_gnt), .idx(arb_idx)
  );

  always_comb begin
    state_nx = state;
    g_nx     = g;
    wc_nx    = word_cnt;
    sc_nx    = stall_cnt;
    ic_nx    = idle_cnt;
    d_nx     = COMMA_WORD;
    k_nx     = K_COMMA;
    busy_nx  = bus.busy;
    done_nx  = '0;
    abort_nx = 1'b0;
    fin      = 1'b0;
    unique case (state)
      IDLE: begin
        if (idle_cnt != IC_W'(IDLE_MIN)) ic_nx = idle_cnt + IC_W'(1);
        if (grant) begin
          g_nx  = arb_idx;
          wc_nx = len_sel;
          sc_nx = '0;
          // Zero-length frames retire at once and keep the saturated idle count.
          if (len_sel == '0) done_nx = arb_gnt;
          else begin
            busy_nx  = 1'b1;
            state_nx = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (dvalid_g) begin
          d_nx  = data_g;
          k_nx  = K_DATA;
          wc_nx = word_cnt - LEN_W'(1);
          sc_nx = '0;
          if (word_cnt == LEN_W'(1)) state_nx = EOF_K;
        end else begin
          d_nx  = PAD_WORD;
          k_nx  = K_PAD;
          sc_nx = stall_cnt + SC_W'(1);
          // Abort drops straight to commas; enough of them reset the CRC.
          if (stall_cnt == SC_W'(STALL_MAX - 1)) begin
            abort_nx = 1'b1;
            done_nx  = g_oh;
            ic_nx    = '0;
            busy_nx  = 1'b0;
            state_nx = IDLE;
          end
        end
      end
      EOF_K: state_nx = CRC_SLOT;
      CRC_SLOT: begin
        d_nx     = '0;
        k_nx     = K_DATA;
        done_nx  = g_oh;
        fin      = 1'b1;
        ic_nx    = '0;
        busy_nx  = 1'b0;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      g             <= '0;
      word_cnt      <= '0;
      stall_cnt     <= '0;
      idle_cnt      <= '0;
      bus.d         <= COMMA_WORD;
      bus.k         <= K_COMMA;
      bus.busy      <= 1'b0;
      bus.src_done  <= '0;
      bus.err_abort <= 1'b0;
      bus.frame_cnt <= '0;
    end else begin
      state         <= state_nx;
      g             <= g_nx;
      word_cnt      <= wc_nx;
      stall_cnt     <= sc_nx;
      idle_cnt      <= ic_nx;
      bus.d         <= d_nx;
      bus.k         <= k_nx;
      bus.busy      <= busy_nx;
      bus.src_done  <= done_nx;
      bus.err_abort <= abort_nx;
      if (fin) bus.frame_cnt <= bus.frame_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_tx_frame_sched.sv
// Scoreboard bench: tests queue expected words/done events, a monitor pops and compares.
module tb_tx_frame_sched;
  import tx_frame_pkg::*;
  localparam int N_REQ = 4, LEN_W = 8, IDLE_MIN = 3, STALL_MAX = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  tx_frame_sched_if #(.N_REQ(N_REQ), .LEN_W(LEN_W)) bus();
  tx_frame_sched #(.N_REQ(N_REQ), .LEN_W(LEN_W), .IDLE_MIN(IDLE_MIN), .STALL_MAX(STALL_MAX))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] d; logic [3:0] k; } word_t;
  typedef struct packed { logic [N_REQ-1:0] done; logic abort; } done_t;

  int n_checks = 0, n_pass = 0, exp_frames = 0;
  word_t exp_q[$];
  done_t done_q[$];
  logic [31:0] src_q [N_REQ][$];
  int flen_q [N_REQ][$];
  logic [N_REQ-1:0] hold = '0;
  bit mon_en = 1'b0, mon_clear = 1'b0;

  task automatic drive();
    for (int i = 0; i < N_REQ; i++) begin
      bus.src_req[i] = flen_q[i].size() > 0;
      bus.src_len[i*LEN_W +: LEN_W] = (flen_q[i].size() > 0) ? LEN_W'(flen_q[i][0]) : '0;
      bus.src_dvalid[i] = (src_q[i].size() > 0) && !hold[i];
      bus.src_data[i*32 +: 32] = (src_q[i].size() > 0) ? src_q[i][0] : 32'hDEAD_BEEF;
    end
  endtask

  task automatic exp_word(input logic [31:0] d, input logic [3:0] k);
    word_t w;
    w.d = d; w.k = k;
    exp_q.push_back(w);
  endtask

  task automatic exp_done(input logic [N_REQ-1:0] done, input logic abort);
    done_t e;
    e.done = done; e.abort = abort;
    done_q.push_back(e);
  endtask

  // Completed frame: payload words then EOF comma and CRC slot.
  task automatic exp_tail(input int s);
    exp_word(COMMA_WORD, K_COMMA);
    exp_word(32'h0, K_DATA);
    exp_done(N_REQ'(1) << s, 1'b0);
    exp_frames++;
  endtask

  task automatic wait_drain(input int max, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < max; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && done_q.size() == 0 && flen_q[0].size() == 0 && flen_q[1].size() == 0 &&
          flen_q[2].size() == 0 && flen_q[3].size() == 0) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  // Source model: pops words on src_rd and frames on src_done after the consuming edge.
  initial begin : src_model
    logic [N_REQ-1:0] rd_s, done_s;
    forever begin
      @(negedge clk);
      rd_s = bus.src_rd;
      done_s = bus.src_done;
      @(posedge clk);
      #1;
      for (int i = 0; i < N_REQ; i++) begin
        if (rd_s[i] && src_q[i].size() > 0) src_q[i].delete(0);
        if (done_s[i] && flen_q[i].size() > 0) flen_q[i].delete(0);
      end
      drive();
    end
  end

  initial begin : monitor
    logic [3:0] pk;
    logic pb, cap;
    int run;
    word_t got, e;
    done_t gd, ed;
    pk = K_COMMA; pb = 1'b0; run = 0;
    forever begin
      @(negedge clk);
      if (mon_clear || !rst_n) begin
        pk = K_COMMA; pb = 1'b0; run = 0; mon_clear = 1'b0;
      end else if (mon_en) begin
        cap = (bus.k != K_COMMA) || (pk == K_DATA && pb);
        if (!cap) run++;
        else begin
          if (bus.k != K_COMMA && run > 0) begin
            n_checks++;
            if (run < IDLE_MIN) $display("FAIL idle_gap: got %0d commas, expected >= %0d", run, IDLE_MIN);
            else n_pass++;
            run = 0;
          end
          got.d = bus.d; got.k = bus.k;
          n_checks++;
          if (exp_q.size() == 0) $display("FAIL word: got d=%h k=%h, expected no word", got.d, got.k);
          else begin
            e = exp_q.pop_front();
            if (got !== e) $display("FAIL word: got d=%h k=%h, expected d=%h k=%h", got.d, got.k, e.d, e.k);
            else n_pass++;
          end
        end
        if (bus.src_done != '0 || bus.err_abort) begin
          gd.done = bus.src_done; gd.abort = bus.err_abort;
          n_checks++;
          if (done_q.size() == 0) $display("FAIL done: got %b/%b, expected none", gd.done, gd.abort);
          else begin
            ed = done_q.pop_front();
            if (gd !== ed) $display("FAIL done: got done=%b abort=%b, expected done=%b abort=%b",
                                    gd.done, gd.abort, ed.done, ed.abort);
            else n_pass++;
          end
        end
        if (bus.src_rd != '0) begin
          n_checks++;
          if (!$onehot(bus.src_rd) || (bus.src_rd & ~bus.src_dvalid) != '0)
            $display("FAIL src_rd: got rd=%b dvalid=%b, expected one-hot within dvalid", bus.src_rd, bus.src_dvalid);
          else n_pass++;
        end
      end
      pk = bus.k; pb = bus.busy;
    end
  end

  task automatic test_reset();
    bus.en = 1'b0;
    drive();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({bus.d, bus.k, bus.busy, bus.src_rd, bus.src_done, bus.err_abort, bus.frame_cnt} !==
        {COMMA_WORD, K_COMMA, 1'b0, 4'b0, 4'b0, 1'b0, 16'd0})
      $display("FAIL reset_state: got d=%h k=%h busy=%b rd=%b done=%b abort=%b cnt=%0d, expected comma/idle/zero",
               bus.d, bus.k, bus.busy, bus.src_rd, bus.src_done, bus.err_abort, bus.frame_cnt);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_checks++;
      if (bus.d !== COMMA_WORD || bus.k !== K_COMMA || bus.busy !== 1'b0)
        $display("FAIL idle_commas: got d=%h k=%h busy=%b, expected d=%h k=%h busy=0", bus.d, bus.k, bus.busy, COMMA_WORD, K_COMMA);
      else n_pass++;
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    mon_clear = 1'b1;
    mon_en = 1'b1;
    for (int s = 0; s < N_REQ; s++) begin
      src_q[s].push_back(32'hA000_0000 + s);
      flen_q[s].push_back(1);
      exp_word(32'hA000_0000 + s, K_DATA);
      exp_tail(s);
    end
    src_q[0].push_back(32'hA000_0004);
    flen_q[0].push_back(1);
    exp_word(32'hA000_0004, K_DATA);
    exp_tail(0);
    @(posedge clk); #2;
    drive();
    repeat (6) @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b0) $display("FAIL en_gate: got busy=%b, expected 0 while en=0", bus.busy);
    else n_pass++;
    @(posedge clk); #2;
    bus.en = 1'b1;
    wait_drain(200, ok);
    n_checks++;
    if (!ok) $display("FAIL rr_drain: got %0d words pending, expected 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_basic();
    bit ok;
    src_q[0].push_back(32'h1111_1111);
    src_q[0].push_back(32'h2222_2222);
    flen_q[0].push_back(2);
    exp_word(32'h1111_1111, K_DATA);
    exp_word(32'h2222_2222, K_DATA);
    exp_tail(0);
    @(posedge clk); #2;
    drive();
    wait_drain(100, ok);
    n_checks++;
    if (!ok || bus.frame_cnt !== 16'(exp_frames))
      $display("FAIL basic_frame_cnt: got %0d (drained=%b), expected %0d", bus.frame_cnt, ok, exp_frames);
    else n_pass++;
  endtask

  task automatic test_stall();
    bit ok, seen;
    src_q[0].push_back(32'h3333_3333);
    src_q[0].push_back(32'h4444_4444);
    flen_q[0].push_back(2);
    exp_word(32'h3333_3333, K_DATA);
    exp_word(PAD_WORD, K_PAD);
    exp_word(PAD_WORD, K_PAD);
    exp_word(32'h4444_4444, K_DATA);
    exp_tail(0);
    @(posedge clk); #2;
    drive();
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      seen = bus.src_rd[0];
    end
    n_checks++;
    if (!seen) $display("FAIL stall_first_rd: got no src_rd[0], expected one within 40 cycles");
    else n_pass++;
    @(posedge clk); #2;
    hold[0] = 1'b1; drive();
    @(posedge clk); @(posedge clk); #2;
    hold[0] = 1'b0; drive();
    wait_drain(100, ok);
    n_checks++;
    if (!ok || bus.frame_cnt !== 16'(exp_frames))
      $display("FAIL stall_frame_cnt: got %0d (drained=%b), expected %0d", bus.frame_cnt, ok, exp_frames);
    else n_pass++;
  endtask

  task automatic test_zero_len();
    bit ok, seen;
    flen_q[2].push_back(0);
    exp_done(4'b0100, 1'b0);
    src_q[3].push_back(32'hC3C3_C3C3);
    flen_q[3].push_back(1);
    exp_word(32'hC3C3_C3C3, K_DATA);
    exp_tail(3);
    @(posedge clk); #2;
    drive();
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      seen = bus.src_done[2];
    end
    @(negedge clk);
    n_checks++;
    if (!seen || bus.src_rd !== 4'b1000)
      $display("FAIL zero_len_next: got done2_seen=%b rd=%b, expected 1 and 1000", seen, bus.src_rd);
    else n_pass++;
    wait_drain(100, ok);
    n_checks++;
    if (!ok || bus.frame_cnt !== 16'(exp_frames))
      $display("FAIL zero_len_frame_cnt: got %0d (drained=%b), expected %0d", bus.frame_cnt, ok, exp_frames);
    else n_pass++;
  endtask

  task automatic test_abort();
    bit ok;
    flen_q[1].push_back(3);
    for (int i = 0; i < STALL_MAX; i++) exp_word(PAD_WORD, K_PAD);
    exp_done(4'b0010, 1'b1);
    @(posedge clk); #2;
    drive();
    wait_drain(100, ok);
    n_checks++;
    if (!ok || bus.frame_cnt !== 16'(exp_frames))
      $display("FAIL abort_frame_cnt: got %0d (drained=%b), expected %0d", bus.frame_cnt, ok, exp_frames);
    else n_pass++;
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.d !== COMMA_WORD || bus.k !== K_COMMA || bus.busy !== 1'b0)
      $display("FAIL abort_commas: got d=%h k=%h busy=%b, expected comma and idle", bus.d, bus.k, bus.busy);
    else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    bit ok, seen;
    mon_en = 1'b0;
    for (int i = 0; i < 5; i++) src_q[0].push_back(32'h5000_0000 + i);
    flen_q[0].push_back(5);
    @(posedge clk); #2;
    drive();
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      seen = bus.src_rd[0];
    end
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (!seen || bus.d !== COMMA_WORD || bus.k !== K_COMMA || bus.busy !== 1'b0 || bus.src_rd !== '0)
      $display("FAIL mid_reset: got rd_seen=%b d=%h k=%h busy=%b rd=%b, expected 1 comma idle 0",
               seen, bus.d, bus.k, bus.busy, bus.src_rd);
    else n_pass++;
    for (int i = 0; i < N_REQ; i++) begin
      src_q[i].delete();
      flen_q[i].delete();
    end
    exp_frames = 0;
    src_q[2].push_back(32'h7777_7777);
    flen_q[2].push_back(1);
    exp_word(32'h7777_7777, K_DATA);
    exp_tail(2);
    drive();
    mon_en = 1'b1;
    repeat (2) begin
      @(negedge clk);
      n_checks++;
      if (bus.src_done !== '0) $display("FAIL mid_reset_done: got %b, expected 0000", bus.src_done);
      else n_pass++;
    end
    @(posedge clk); #2;
    rst_n = 1'b1;
    wait_drain(100, ok);
    n_checks++;
    if (!ok || bus.frame_cnt !== 16'(exp_frames))
      $display("FAIL post_reset_frame_cnt: got %0d (drained=%b), expected %0d", bus.frame_cnt, ok, exp_frames);
    else n_pass++;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000 time units");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_round_robin();
    test_basic();
    test_stall();
    test_zero_len();
    test_abort();
    test_reset_mid_frame();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
